// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the pattern transmitter and its matching
// sequence detector.
//   seq_state_t : FSM state encoding (IDLE / SHIFT / DONE)
//   PAT_W_DEF   : default maximum pattern length in bits
//   REP_W_DEF   : default width of the repeat-count field
package seq_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int REP_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/seq_piso.sv
// seq_piso: parallel-in / serial-out datapath of seq_pattern_tx.
//   clk, rst_n : clock, async active-low reset
//   load       : capture pattern/len, point index at len-1
//   shift      : drive pattern bit at index onto x (x_valid=1), step index
//   pattern    : parallel pattern, bit [len-1] goes out first
//   len        : pattern length in bits
//   x, x_valid : registered serial output; x is 0 whenever x_valid is 0
//   idx_zero   : current index is 0 (the bit being shifted is the last one)
module seq_piso #(
  parameter int PAT_W = 8,
  parameter int LW    = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LW-1:0]    len,
  output logic             x,
  output logic             x_valid,
  output logic             idx_zero
);

  logic [PAT_W-1:0] pat_q;
  logic [LW-1:0]    len_q;
  logic [LW-1:0]    idx;
  logic [PAT_W-1:0] pat_sh;

  // Shift instead of a variable bit-select keeps the index width free of
  // the pattern width.
  assign pat_sh   = pat_q >> idx;
  assign idx_zero = (idx == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q   <= '0;
      len_q   <= '0;
      idx     <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
    end else begin
      x       <= 1'b0;
      x_valid <= 1'b0;
      if (load) begin
        pat_q <= pattern;
        len_q <= len;
        idx   <= len - LW'(1);
      end else if (shift) begin
        x       <= pat_sh[0];
        x_valid <= 1'b1;
        // Wrap back to the top bit so the next repetition follows with no gap.
        idx     <= idx_zero ? (len_q - LW'(1)) : (idx - LW'(1));
      end
    end
  end

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial bit-pattern transmitter driving a sequence detector.
//   clk, rst_n : clock, async active-low reset
//   start      : begin transmission (accepted only in IDLE)
//   abort      : cancel active transmission, wins over start
//   pattern    : pattern bits, [len-1] sent first
//   len        : bits per repetition, legal 2..PAT_W
//   reps       : extra repetitions (total = reps+1)
//   x, x_valid : registered serial output
//   busy       : state is not IDLE
//   done       : one-cycle pulse after the final bit
//   err        : one-cycle pulse when start carries an illegal len
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int REP_W = REP_W_DEF,
  parameter int LW    = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LW-1:0]    len,
  input  logic [REP_W-1:0] reps,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  seq_state_t       state, nxt;
  logic [REP_W-1:0] rep_cnt;
  logic             tail;      // final bit already shifted out
  logic             len_ok;
  logic             load, shift, rep_dec, tail_set, err_n;
  logic             idx_zero;

  assign len_ok = (len >= LW'(2)) && (len <= LW'(PAT_W));
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  always_comb begin
    nxt      = state;
    load     = 1'b0;
    shift    = 1'b0;
    rep_dec  = 1'b0;
    tail_set = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (len_ok) begin
            load = 1'b1;
            nxt  = SHIFT;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (abort) begin
          nxt = IDLE;
        end else if (tail) begin
          // Last bit is on x this cycle; next cycle is the done cycle.
          nxt = DONE;
        end else begin
          shift = 1'b1;
          if (idx_zero) begin
            if (rep_cnt != '0) rep_dec  = 1'b1;
            else               tail_set = 1'b1;
          end
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rep_cnt <= '0;
      tail    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= nxt;
      err   <= err_n;
      if (load)         rep_cnt <= reps;
      else if (rep_dec) rep_cnt <= rep_cnt - REP_W'(1);
      if (load || nxt == IDLE) tail <= 1'b0;
      else if (tail_set)       tail <= 1'b1;
    end
  end

  seq_piso #(.PAT_W(PAT_W), .LW(LW)) u_piso (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift    (shift),
    .pattern  (pattern),
    .len      (len),
    .x        (x),
    .x_valid  (x_valid),
    .idx_zero (idx_zero)
  );

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed bench for seq_pattern_tx with hand-computed
// expected bit streams and a behavioural 1010 detector on the serial output.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] reps;
  logic       x, x_valid, busy, done, err;

  int n_chk  = 0;
  int n_pass = 0;

  // capture results
  logic [63:0] c_bits;
  int c_nb, c_nd, c_first, c_last, c_didx, c_z, c_xbad, c_pbusy;

  always #5 clk = ~clk;

  seq_pattern_tx dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .pattern (pattern),
    .len     (len),
    .reps    (reps),
    .x       (x),
    .x_valid (x_valid),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called at a negedge; returns at the next negedge (start sampled between).
  task automatic drive_start(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
    start = 1'b1; pattern = p; len = l; reps = r;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Samples each negedge until two cycles after done or maxc cycles.
  // rp_at >= 0 re-pulses start with another pattern at that sample index;
  // sid drives start during the done cycle.
  task automatic capture(input int maxc, input int rp_at, input bit sid);
    logic [3:0] win;
    win = '0;
    c_bits = '0; c_nb = 0; c_nd = 0; c_first = -1; c_last = -1;
    c_didx = -1; c_z = 0; c_xbad = 0; c_pbusy = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (x_valid) begin
        c_bits = {c_bits[62:0], x};
        c_nb++;
        if (c_first < 0) c_first = i;
        c_last = i;
        win = {win[2:0], x};
        if (win == 4'b1010) c_z++;
      end else if (x !== 1'b0) c_xbad++;
      if (done) begin
        c_nd++;
        if (c_didx < 0) c_didx = i;
      end else if (c_didx >= 0 && busy) c_pbusy++;
      start = 1'b0;
      if (i == rp_at) begin start = 1'b1; pattern = 8'h3C; len = 4'd5; reps = 4'd1; end
      if (sid && done) start = 1'b1;
      if (c_didx >= 0 && i >= c_didx + 2) break;
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string tag, input logic [63:0] bits, input int nb);
    chk({tag, "_bits"}, c_bits, bits);
    chk({tag, "_nbits"}, 64'(c_nb), 64'(nb));
    chk({tag, "_first"}, 64'(c_first), 64'd0);
    chk({tag, "_contig"}, 64'(c_last - c_first + 1), 64'(nb));
    chk({tag, "_ndone"}, 64'(c_nd), 64'd1);
    chk({tag, "_didx"}, 64'(c_didx), 64'(c_last + 1));
    chk({tag, "_xzero"}, 64'(c_xbad), 64'd0);
  endtask

  initial begin
    int nv, dseen;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    pattern = '0; len = '0; reps = '0;
    #12;
    chk("rst_x", 64'(x), 64'd0);
    chk("rst_xv", 64'(x_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // single 1010, latency and detector
    drive_start(8'h0A, 4'd4, 4'd0);
    chk("lat_busy", 64'(busy), 64'd1);
    chk("lat_xv", 64'(x_valid), 64'd0);
    capture(40, -1, 1'b0);
    check_run("r0", 64'hA, 4);
    chk("r0_z", 64'(c_z), 64'd1);

    // three back-to-back repetitions
    drive_start(8'h0A, 4'd4, 4'd2);
    capture(60, -1, 1'b0);
    check_run("r2", 64'hAAA, 12);

    // illegal lengths
    drive_start(8'h0A, 4'd1, 4'd0);
    chk("len1_err", 64'(err), 64'd1);
    chk("len1_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("len1_err_off", 64'(err), 64'd0);
    chk("len1_xv", 64'(x_valid), 64'd0);
    drive_start(8'h0A, 4'd9, 4'd0);
    chk("len9_err", 64'(err), 64'd1);
    chk("len9_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("len9_err_off", 64'(err), 64'd0);
    chk("len9_xv", 64'(x_valid), 64'd0);

    // abort + start in IDLE: abort wins
    start = 1'b1; abort = 1'b1; pattern = 8'h0A; len = 4'd4;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abst_busy", 64'(busy), 64'd0);
    chk("abst_err", 64'(err), 64'd0);

    // abort on 3rd valid cycle
    drive_start(8'hB5, 4'd8, 4'd0);
    nv = 0; c_bits = '0;
    for (int i = 0; i < 20 && nv < 3; i++) begin
      @(negedge clk);
      if (x_valid) begin nv++; c_bits = {c_bits[62:0], x}; end
    end
    chk("ab_bits", c_bits, 64'h5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_xv", 64'(x_valid), 64'd0);
    chk("ab_busy", 64'(busy), 64'd0);
    chk("ab_err", 64'(err), 64'd0);
    dseen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || x_valid) dseen++;
    end
    chk("ab_nodone", 64'(dseen), 64'd0);

    // async reset mid-shift
    drive_start(8'h0A, 4'd4, 4'd3);
    nv = 0;
    for (int i = 0; i < 20 && nv < 2; i++) begin
      @(negedge clk);
      if (x_valid) nv++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("ar_x", 64'(x), 64'd0);
    chk("ar_xv", 64'(x_valid), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    dseen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy || x_valid || done) dseen++;
    end
    chk("ar_idle", 64'(dseen), 64'd0);
    drive_start(8'h35, 4'd6, 4'd0);
    capture(40, -1, 1'b0);
    check_run("ar_new", 64'h35, 6);

    // start while busy and in done cycle ignored
    drive_start(8'hC3, 4'd8, 4'd0);
    capture(40, 2, 1'b1);
    check_run("rp", 64'hC3, 8);
    chk("rp_postbusy", 64'(c_pbusy), 64'd0);

    // maximum repeat count, minimum length
    drive_start(8'h02, 4'd2, 4'd15);
    capture(80, -1, 1'b0);
    check_run("rmax", 64'hAAAA_AAAA, 32);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
